// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: board geometry, cell encoding, move status codes
// and the drop engine's FSM state.
package connect4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam logic [5:0] MAX_MOVES = 6'd42;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Row 0 is the top of the board, row ROWS-1 the bottom.
  typedef cell_t [0:ROWS-1][0:COLS-1] board_t;

  typedef enum logic [1:0] {
    OK         = 2'b00,
    COL_FULL   = 2'b01,
    BAD_COL    = 2'b10,
    BAD_PLAYER = 2'b11
  } move_status_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } eng_state_t;

endpackage

// File: rtl/move_drop_engine.sv
// Drops a player's token into the lowest empty cell of the requested column,
// scanning one row per cycle from the bottom. Owns and exports the board.
module move_drop_engine
  import connect4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         move_valid,
  input  logic [2:0]   move_col,
  input  logic [1:0]   move_player,
  output logic         ready,
  output board_t       board,
  output logic         done,
  output move_status_t status,
  output logic [2:0]   placed_row,
  output logic [2:0]   placed_col,
  output logic [5:0]   move_count,
  output logic         board_full,
  output eng_state_t   dbg_state
);

  // Handshake: a request transfers on a rising edge where move_valid && ready;
  // ready is high only in IDLE, so a held move_valid is consumed once per move
  // and the result is reported by a single-cycle done pulse with status.

  eng_state_t   state;
  logic [2:0]   col_q;
  logic [1:0]   player_q;
  logic [2:0]   row_q;
  move_status_t err_q;
  logic         top_free;
  cell_t        cur_cell;

  always_comb begin
    top_free = 1'b0;
    for (int c = 0; c < COLS; c++)
      if (move_col == 3'(c)) top_free = (board[0][c] == EMPTY);
  end

  assign cur_cell  = board[row_q][col_q];
  assign dbg_state = state;

  // Validation is registered at the accept edge and reported from SCAN, so
  // rejections and bottom-row drops share the same one-edge latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      board      <= '0;
      done       <= 1'b0;
      status     <= OK;
      placed_row <= '0;
      placed_col <= '0;
      move_count <= '0;
      board_full <= 1'b0;
      col_q      <= '0;
      player_q   <= '0;
      row_q      <= '0;
      err_q      <= OK;
    end else if (clear) begin
      state      <= IDLE;
      ready      <= 1'b1;
      board      <= '0;
      done       <= 1'b0;
      move_count <= '0;
      board_full <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          board_full <= (move_count == MAX_MOVES);
          if (move_valid) begin
            col_q    <= move_col;
            player_q <= move_player;
            row_q    <= 3'(ROWS - 1);
            if (move_col > 3'(COLS - 1))
              err_q <= BAD_COL;
            else if (move_player == 2'b00 || move_player == 2'b11)
              err_q <= BAD_PLAYER;
            else if (!top_free)
              err_q <= COL_FULL;
            else
              err_q <= OK;
            state <= SCAN;
            ready <= 1'b0;
          end
        end
        SCAN: begin
          if (err_q != OK) begin
            done   <= 1'b1;
            status <= err_q;
            state  <= DONE;
          end else if (cur_cell == EMPTY) begin
            board[row_q][col_q] <= cell_t'(player_q);
            placed_row <= row_q;
            placed_col <= col_q;
            move_count <= move_count + 6'd1;
            board_full <= (move_count == MAX_MOVES - 6'd1);
            done       <= 1'b1;
            status     <= OK;
            state      <= DONE;
          end else begin
            row_q <= row_q - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_drop_engine.sv
// Self-checking bench for move_drop_engine against a gravity-drop board model.
module tb_move_drop_engine;
  import connect4_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         move_valid;
  logic [2:0]   move_col;
  logic [1:0]   move_player;
  logic         ready;
  board_t       board;
  logic         done;
  move_status_t status;
  logic [2:0]   placed_row;
  logic [2:0]   placed_col;
  logic [5:0]   move_count;
  logic         board_full;
  eng_state_t   dbg_state;

  int checks = 0;
  int passed = 0;
  int model[6][7];
  int model_count;

  move_drop_engine dut (
    .clk(clk), .rst(rst), .clear(clear), .move_valid(move_valid),
    .move_col(move_col), .move_player(move_player), .ready(ready),
    .board(board), .done(done), .status(status), .placed_row(placed_row),
    .placed_col(placed_col), .move_count(move_count), .board_full(board_full),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void model_wipe();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) model[r][c] = 0;
    model_count = 0;
  endfunction

  // Gravity rule: token lands in the lowest empty cell of the column.
  function automatic void model_move(input int col, input int pl, output int st, output int row);
    row = -1;
    if (col > 6) st = 2;
    else if (pl == 0 || pl == 3) st = 3;
    else if (model[0][col] != 0) st = 1;
    else begin
      st = 0;
      for (int r = 5; r >= 0; r--)
        if (model[r][col] == 0 && row < 0) row = r;
      model[row][col] = pl;
      model_count++;
    end
  endfunction

  function automatic bit board_ok();
    logic [1:0] b;
    board_ok = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        b = board[r][c];
        if (b !== 2'(model[r][c])) board_ok = 1'b0;
      end
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
  task automatic do_move(input int col, input int pl, output bit seen, output int lat,
                         output int got_st, output int got_row, output int got_col,
                         output bit rdy_done, output bit done_after, output bit rdy_after);
    move_valid = 1'b1; move_col = 3'(col); move_player = 2'(pl);
    @(posedge clk); #1;
    move_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    got_st = int'(status); got_row = int'(placed_row); got_col = int'(placed_col);
    rdy_done = ready;
    @(posedge clk); #1;
    done_after = done; rdy_after = ready;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_wipe();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; move_valid = 1'b0; move_col = '0; move_player = '0;
    model_wipe();
    #3;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if (move_count !== 6'd0) $display("FAIL reset_count got %0d want 0", move_count); else passed++;
    checks++; if (!board_ok()) $display("FAIL reset_board got nonempty want empty"); else passed++;
    checks++; if ({status, placed_row, placed_col, board_full} !== 9'd0)
      $display("FAIL reset_misc got %h want 0", {status, placed_row, placed_col, board_full}); else passed++;
    checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want 0", dbg_state); else passed++;
    #13 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow;
    model_move(3, 1, est, erow);
    do_move(3, 1, seen, lat, st, row, col, rd, da, ra);
    checks++; if (!seen || lat != 1) $display("FAIL single_latency got %0d want 1", lat); else passed++;
    checks++; if (st != est || row != 5 || col != 3)
      $display("FAIL single_result got st=%0d row=%0d col=%0d want st=0 row=5 col=3", st, row, col); else passed++;
    checks++; if (rd !== 1'b0 || da !== 1'b0 || ra !== 1'b1)
      $display("FAIL single_handshake got ready_in_done=%b done_after=%b ready_after=%b want 0 0 1", rd, da, ra); else passed++;
    checks++; if (!board_ok() || move_count !== 6'd1)
      $display("FAIL single_board got count=%0d want 1 and matching board", move_count); else passed++;
  endtask

  task automatic test_column_fill();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow;
    for (int i = 0; i < 6; i++) begin
      model_move(0, (i % 2 == 0) ? 1 : 2, est, erow);
      do_move(0, (i % 2 == 0) ? 1 : 2, seen, lat, st, row, col, rd, da, ra);
      checks++; if (!seen || st != 0 || row != 5 - i || lat != i + 1)
        $display("FAIL fill_drop%0d got st=%0d row=%0d lat=%0d want st=0 row=%0d lat=%0d", i, st, row, lat, 5 - i, i + 1);
      else passed++;
    end
    checks++; if (board[0][0] !== P2) $display("FAIL fill_top got %0d want 2", board[0][0]); else passed++;
    model_move(0, 1, est, erow);
    do_move(0, 1, seen, lat, st, row, col, rd, da, ra);
    checks++; if (!seen || st != 1 || lat != 1) $display("FAIL fill_full got st=%0d lat=%0d want st=1 lat=1", st, lat); else passed++;
    checks++; if (!board_ok() || move_count !== 6'(model_count))
      $display("FAIL fill_unchanged got count=%0d want %0d", move_count, model_count); else passed++;
  endtask

  task automatic test_errors();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow;
    int cols[4] = '{7, 2, 7, 4};
    int pls[4]  = '{1, 3, 3, 0};
    for (int i = 0; i < 4; i++) begin
      model_move(cols[i], pls[i], est, erow);
      do_move(cols[i], pls[i], seen, lat, st, row, col, rd, da, ra);
      checks++; if (!seen || st != est || lat != 1)
        $display("FAIL error_case%0d got st=%0d lat=%0d want st=%0d lat=1", i, st, lat, est); else passed++;
      checks++; if (!board_ok() || move_count !== 6'(model_count))
        $display("FAIL error_state%0d got count=%0d want %0d", i, move_count, model_count); else passed++;
    end
  endtask

  task automatic test_random();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow, c, p, bad;
    do_clear();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      c = $urandom_range(0, 7); p = $urandom_range(0, 3);
      model_move(c, p, est, erow);
      do_move(c, p, seen, lat, st, row, col, rd, da, ra);
      if (!seen || st != est || lat != ((est == 0) ? 6 - erow : 1) ||
          (est == 0 && (row != erow || col != c))) begin
        $display("FAIL random_move%0d col=%0d pl=%0d got st=%0d row=%0d lat=%0d want st=%0d row=%0d", i, c, p, st, row, lat, est, erow);
        bad++;
      end
    end
    checks++; if (bad != 0) $display("FAIL random_moves got %0d bad want 0", bad); else passed++;
    checks++; if (!board_ok() || move_count !== 6'(model_count))
      $display("FAIL random_board got count=%0d want %0d", move_count, model_count); else passed++;
  endtask

  task automatic test_board_full();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow, c, bad;
    do_clear();
    bad = 0;
    for (int i = 0; i < 42; i++) begin
      do c = $urandom_range(0, 6); while (model[0][c] != 0);
      model_move(c, (i % 2) + 1, est, erow);
      do_move(c, (i % 2) + 1, seen, lat, st, row, col, rd, da, ra);
      if (!seen || st != 0 || row != erow) begin
        $display("FAIL full_move%0d got st=%0d row=%0d want st=0 row=%0d", i, st, row, erow);
        bad++;
      end
    end
    checks++; if (bad != 0) $display("FAIL full_moves got %0d bad want 0", bad); else passed++;
    checks++; if (board_full !== 1'b1 || move_count !== 6'd42)
      $display("FAIL full_flag got full=%b count=%0d want 1 42", board_full, move_count); else passed++;
    c = $urandom_range(0, 6);
    do_move(c, 1, seen, lat, st, row, col, rd, da, ra);
    checks++; if (!seen || st != 1) $display("FAIL full_reject got st=%0d want 1", st); else passed++;
    checks++; if (!board_ok()) $display("FAIL full_board got changed board want unchanged"); else passed++;
  endtask

  task automatic test_clear_mid_scan();
    bit stray;
    do_clear();
    model[5][2] = 1; model[4][2] = 2; model[3][2] = 1; model_count = 3;
    force_free_drop(2, 3);
    move_valid = 1'b1; move_col = 3'd2; move_player = 2'd2;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_wipe();
    checks++; if (done !== 1'b0 || ready !== 1'b1)
      $display("FAIL clear_abort got done=%b ready=%b want 0 1", done, ready); else passed++;
    checks++; if (!board_ok() || move_count !== 6'd0 || board_full !== 1'b0)
      $display("FAIL clear_wipe got count=%0d full=%b want 0 0", move_count, board_full); else passed++;
    stray = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (done !== 1'b0) stray = 1'b1; end
    checks++; if (stray) $display("FAIL clear_no_done got pulse want none"); else passed++;
  endtask

  // Places n alternating tokens in a column through the DUT (model already set).
  task automatic force_free_drop(input int c, input int n);
    bit seen, rd, da, ra; int lat, st, row, col;
    for (int i = 0; i < n; i++)
      do_move(c, (i % 2) + 1, seen, lat, st, row, col, rd, da, ra);
  endtask

  task automatic test_async_reset();
    bit seen, rd, da, ra; int lat, st, row, col, est, erow;
    do_clear();
    model[5][1] = 1; model[4][1] = 2; model_count = 2;
    force_free_drop(1, 2);
    move_valid = 1'b1; move_col = 3'd1; move_player = 2'd1;
    @(posedge clk); #1;
    move_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || ready !== 1'b1 || move_count !== 6'd0 || board !== '0)
      $display("FAIL async_reset got done=%b ready=%b count=%0d want 0 1 0", done, ready, move_count); else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_wipe();
    @(posedge clk); #1;
    model_move(6, 2, est, erow);
    do_move(6, 2, seen, lat, st, row, col, rd, da, ra);
    checks++; if (!seen || st != 0 || row != 5 || col != 6)
      $display("FAIL post_reset_move got st=%0d row=%0d col=%0d want 0 5 6", st, row, col); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_column_fill();
    test_errors();
    test_random();
    test_board_full();
    test_clear_mid_scan();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
